fp_addsub_issue: RTL

- Sequential producer side of the unpacked add/sub datapath interface.
- Accepts packed IEEE-754 single-precision operand pairs over a valid/ready request channel and unpacks them into sign/exponent/significand fields.
- Drives those fields to the combinational add/sub datapath and holds them stable for a fixed multicycle settle window, then captures fp_out/err_o.
- Returns the result over a valid/ready response channel and keeps an op counter and sticky error flags.

---
 rtl/fp_addsub_issue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fp_addsub_issue.sv
// Issue/capture stage for the combinational single-precision add/sub datapath.
// Unpacks an operand pair, holds it for a settle window, then returns the sampled result.
module fp_addsub_issue #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_opcode,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             opcode,
  output logic             sign1,
  output logic [7:0]       exp1,
  output logic [22:0]      sig1,
  output logic             sign2,
  output logic [7:0]       exp2,
  output logic [22:0]      sig2,
  input  logic [31:0]      fp_out,
  input  logic [2:0]       err_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [2:0]       rsp_err,
  output logic [2:0]       err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] op_count
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $fatal(1, "fp_addsub_issue: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_opcode;
  logic             r_sign1;
  logic [7:0]       r_exp1;
  logic [22:0]      r_sig1;
  logic             r_sign2;
  logic [7:0]       r_exp2;
  logic [22:0]      r_sig2;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic [2:0]       r_rsp_err;
  logic [2:0]       r_err_sticky;
  logic [CNT_W-1:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_opcode     <= 1'b0;
      r_sign1      <= 1'b0;
      r_exp1       <= '0;
      r_sig1       <= '0;
      r_sign2      <= 1'b0;
      r_exp2       <= '0;
      r_sig2       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= '0;
      r_err_sticky <= '0;
      r_op_count   <= '0;
    end else begin
      if (err_clr) r_err_sticky <= '0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_opcode <= req_opcode;
            r_sign1  <= req_a[31];
            r_exp1   <= req_a[30:23];
            r_sig1   <= req_a[22:0];
            r_sign2  <= req_b[31];
            r_exp2   <= req_b[30:23];
            r_sig2   <= req_b[22:0];
            r_cnt    <= LP_CNT_INIT;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          // Operand fields stay frozen here so the datapath output can settle
          if (r_cnt == 4'd0) begin
            r_rsp_data  <= fp_out;
            r_rsp_err   <= err_o;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_op_count   <= r_op_count + CNT_W'(1);
            // A coincident clear wipes history first, then this response is folded in
            r_err_sticky <= (err_clr ? 3'b000 : r_err_sticky) | r_rsp_err;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign opcode     = r_opcode;
  assign sign1      = r_sign1;
  assign exp1       = r_exp1;
  assign sig1       = r_sig1;
  assign sign2      = r_sign2;
  assign exp2       = r_exp2;
  assign sig2       = r_sig2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign err_sticky = r_err_sticky;
  assign op_count   = r_op_count;

endmodule
